// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access sequencer: store lane steering, load extraction, req/gnt/rvalid handshake.
// Define DM_ALIGN_CHECK_EN to reject misaligned half/word accesses without touching memory.
module dm_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_type,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        m_req,
  input  logic        m_gnt,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic          we_q;
  logic [1:0]    type_q;
  logic          sign_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic          m_req_q;

  logic          misalign;
  logic          illegal;
  logic          to_hit;
  logic [3:0]    byteen_d;
  logic [31:0]   wdata_d;
  logic [31:0]   load_ext_d;
  logic [7:0]    lane8;
  logic [15:0]   lane16;

  always_comb begin
`ifdef DM_ALIGN_CHECK_EN
    misalign = ((req_type == 2'b01) && req_addr[0]) ||
               ((req_type == 2'b00) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    illegal = (req_type == 2'b11) || misalign;
  end

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    byteen_d = 4'b0000;
    wdata_d  = wdata_q;
    case (type_q)
      2'b00: begin
        byteen_d = 4'b1111;
        wdata_d  = wdata_q;
      end
      2'b01: begin
        byteen_d = 4'b0011 << {addr_q[1], 1'b0};
        wdata_d  = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byteen_d = 4'b0001 << addr_q[1:0];
        wdata_d  = {4{wdata_q[7:0]}};
      end
      default: begin
        byteen_d = 4'b0000;
        wdata_d  = wdata_q;
      end
    endcase
  end

  always_comb begin
    lane8  = m_rdata[7:0];
    lane16 = addr_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (addr_q[1:0])
      2'b00:   lane8 = m_rdata[7:0];
      2'b01:   lane8 = m_rdata[15:8];
      2'b10:   lane8 = m_rdata[23:16];
      default: lane8 = m_rdata[31:24];
    endcase
    case (type_q)
      2'b01:   load_ext_d = {{16{sign_q & lane16[15]}}, lane16};
      2'b10:   load_ext_d = {{24{sign_q & lane8[7]}}, lane8};
      default: load_ext_d = m_rdata;
    endcase
  end

  // A handshake in the same cycle as the timeout takes priority over the abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      type_q       <= 2'b00;
      sign_q       <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      m_req_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            type_q  <= req_type;
            sign_q  <= req_sign;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            if (illegal) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              m_req_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (m_gnt) begin
            m_req_q <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            if (we_q) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (to_hit) begin
            m_req_q      <= 1'b0;
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (m_rvalid) begin
            resp_rdata_q <= load_ext_d;
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
          end else if (to_hit) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign m_req      = m_req_q;
  assign m_we       = m_req_q & we_q;
  assign m_addr     = m_req_q ? {addr_q[31:2], 2'b00} : 32'd0;
  assign m_byteen   = m_req_q ? byteen_d : 4'b0000;
  assign m_wdata    = (m_req_q && we_q) ? wdata_d : 32'd0;

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- MEM-stage data-memory access sequencer for the pipelined MIPS core.
- Store path: narrows 32-bit register data into byte lanes with byte enables.
- Load path: picks the addressed byte or halfword out of the returned word, then sign- or zero-extends it to 32 bits.
- Talks to a variable-latency memory port with a req/gnt/rvalid handshake. Raises busy so the hazard unit can freeze the pipeline.

Parameters:
- TIMEOUT, default 255: cycles spent in ISSUE+WAIT before the access aborts with resp_err. 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  access request; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  2  00 word, 01 half, 10 byte, 11 reserved.
- req_sign  in  1  load extension: 1 sign, 0 zero.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned, reserved type, or timeout.
- resp_rdata  out  32  extended load data; held until the next load completes.
- m_req  out  1  memory request.
- m_gnt  in  1  memory accepted the request.
- m_we  out  1  memory write.
- m_addr  out  32  word address: {addr[31:2], 2'b00}.
- m_byteen  out  4  byte-lane enables.
- m_wdata  out  32  lane-replicated store data.
- m_rvalid  in  1  read data valid.
- m_rdata  in  32  read word.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0, including resp_rdata; timeout counter 0; captured request regs 0. Reset asserted mid-access drops m_req at once and the in-flight access is discarded.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On req_valid, capture req_* into registers.
  - Legal request -> ISSUE.
  - Illegal request (reserved type, or misaligned when the check is enabled) -> DONE with err=1, and m_req is never raised.
- ISSUE:
  - m_req=1. m_we, m_addr, m_byteen, m_wdata are driven from the captured registers and stay stable until m_gnt.
  - m_gnt with store -> DONE.
  - m_gnt with load -> WAIT.
- WAIT: m_req=0. On m_rvalid, latch the extended m_rdata into resp_rdata -> DONE. m_rvalid seen in any other state is ignored.
- DONE: resp_valid=1 for exactly one cycle, resp_err as determined -> IDLE.
- busy timing: busy rises the cycle after acceptance and falls the cycle after DONE.
  - Minimum load latency with gnt and rvalid both immediate: 3 cycles from acceptance to resp_valid.
  - Minimum store latency: 2 cycles.
- req_valid while busy is ignored; the pipeline holds it.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1],1'b0}.
  - word: 4'b1111.
- Store data replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata unchanged.
- Load extraction:
  - byte: lane = m_rdata[8*addr[1:0] +: 8].
  - half: lane = m_rdata[16*addr[1] +: 16].
  - Upper bits are filled with lane MSB if req_sign, else 0. Word loads pass through; req_sign is ignored.
- Timeout:
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT (and TIMEOUT != 0) -> DONE with err=1 and m_req dropped. resp_rdata is left unchanged.
  - A handshake arriving in the same cycle as the timeout wins; no error is raised.
- Failed loads (err=1) leave resp_rdata unchanged.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is rejected in IDLE and completes via DONE with resp_err=1. No memory access takes place.
- Undefined: no alignment error. Half accesses use only addr[1]; word accesses ignore addr[1:0]. The reserved req_type still produces an error.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, gnt in the ISSUE cycle -> m_byteen=4'b1000, m_wdata=0xABABABAB, m_addr=0x1000; resp_valid 2 cycles after acceptance, err=0.
- Load byte, signed then unsigned: addr=0x2001, m_rdata=0x12348056 -> signed resp_rdata=0xFFFFFF80; unsigned resp_rdata=0x00000080.
- Load half, signed: addr=0x2002, m_rdata=0x9ABC1234 -> resp_rdata=0xFFFF9ABC. Insert 4 wait cycles before rvalid -> busy stays 1 throughout, then resp_valid is a single 1-cycle pulse.
- Misaligned word, addr=0x3002, with DM_ALIGN_CHECK_EN -> m_req never asserted, resp_valid=1 with resp_err=1. Without the macro -> m_addr=0x3000, m_byteen=4'b1111, err=0.
- Timeout with TIMEOUT=8 and m_gnt held 0 -> resp_err=1 at the 8th ISSUE cycle, m_req drops, resp_rdata unchanged.
- Reset mid-WAIT -> all outputs 0 asynchronously. A late m_rvalid after reset causes no resp_valid. A new request afterwards completes normally.
